// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle digit-serial adder with start/done handshake
//
// Adds a + b + ci, DIGIT bits per clock, over N = WIDTH/DIGIT clocks, with a
// ripple carry register between digits.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request; accepted in IDLE or DONE
//   a      in   WIDTH  operand A, captured on accept
//   b      in   WIDTH  operand B, captured on accept
//   ci     in   1      carry-in, captured on accept
//   busy   out  1      high while an add is in progress
//   done   out  1      one-cycle pulse; s/co/ov valid from this cycle on
//   s      out  WIDTH  sum (a+b+ci) mod 2^WIDTH
//   co     out  1      unsigned carry-out
//   ov     out  1      signed (two's complement) overflow
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    // Guard the divide so a bad DIGIT reaches the elaboration check below
    // instead of producing a meaningless N.
    localparam int N  = WIDTH / ((DIGIT < 1) ? 1 : DIGIT);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % ((DIGIT < 1) ? 1 : DIGIT)) != 0) begin : g_param_check
            $error("serial_adder: WIDTH must be >= 1, DIGIT >= 1, and WIDTH %% DIGIT == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   dsum;
    logic             msb_cin;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic             last;

    // One digit step: low DIGIT bits of each shift register plus the carry.
    assign dsum = {1'b0, sh_a[DIGIT-1:0]} + {1'b0, sh_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

    // Carry into the digit's top bit, recovered from the sum bit and its two
    // operand bits; on the last digit this is the carry into the word MSB.
    assign msb_cin = dsum[DIGIT-1] ^ sh_a[DIGIT-1] ^ sh_b[DIGIT-1];

    assign last = (cnt == CW'(N - 1));

    // With a single digit there is nothing to shift; the digit sum is the result.
    generate
        if (N == 1) begin : g_single
            assign acc_next = dsum[DIGIT-1:0];
            assign a_next   = '0;
            assign b_next   = '0;
        end else begin : g_multi
            assign acc_next = {dsum[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
            assign a_next   = {{DIGIT{1'b0}}, sh_a[WIDTH-1:DIGIT]};
            assign b_next   = {{DIGIT{1'b0}}, sh_b[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= ci;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sh_a  <= a_next;
                    sh_b  <= b_next;
                    acc   <= acc_next;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        s     <= acc_next;
                        co    <= dsum[DIGIT];
                        ov    <= msb_cin ^ dsum[DIGIT];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (W8/D1, W8/D4, W3/D1)
module tb_serial_adder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a     = 8'h00;
    logic [7:0] b     = 8'h00;
    logic       ci    = 1'b0;

    logic       busy8, done8, co8, ov8;
    logic [7:0] s8;
    logic       busy4, done4, co4, ov4;
    logic [7:0] s4;
    logic       busy3, done3, co3, ov3;
    logic [2:0] s3;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci),
        .busy(busy8), .done(done8), .s(s8), .co(co8), .ov(ov8)
    );
    serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci),
        .busy(busy4), .done(done4), .s(s4), .co(co4), .ov(ov4)
    );
    serial_adder #(.WIDTH(3), .DIGIT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a[2:0]), .b(b[2:0]), .ci(ci),
        .busy(busy3), .done(done3), .s(s3), .co(co3), .ov(ov3)
    );

    logic       dn[3];
    logic       bz[3];
    logic [7:0] so[3];
    logic       coo[3];
    logic       ovo[3];

    always_comb begin
        dn[0] = done8;  bz[0] = busy8;  so[0] = s8;           coo[0] = co8;  ovo[0] = ov8;
        dn[1] = done4;  bz[1] = busy4;  so[1] = s4;           coo[1] = co4;  ovo[1] = ov4;
        dn[2] = done3;  bz[2] = busy3;  so[2] = {5'b0, s3};   coo[2] = co3;  ovo[2] = ov3;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain integer addition, signed overflow from operand/result signs.
    function automatic logic [9:0] model(input int w, input logic [7:0] x, input logic [7:0] y, input logic c);
        int mask, xx, yy, sum, ss, cout, sx, sy, sr;
        logic [9:0] r;
        mask = (1 << w) - 1;
        xx   = int'(x) & mask;
        yy   = int'(y) & mask;
        sum  = xx + yy + int'(c);
        ss   = sum & mask;
        cout = (sum >> w) & 1;
        sx   = (xx >> (w - 1)) & 1;
        sy   = (yy >> (w - 1)) & 1;
        sr   = (ss >> (w - 1)) & 1;
        r[7:0] = ss[7:0];
        r[8]   = cout[0];
        r[9]   = (sx == sy) && (sr != sx);
        return r;
    endfunction

    int         lat_exp[3] = '{8, 2, 3};
    logic [7:0] prev_s[3]  = '{8'h00, 8'h00, 8'h00};
    logic       prev_co[3] = '{1'b0, 1'b0, 1'b0};
    logic       prev_ov[3] = '{1'b0, 1'b0, 1'b0};
    bit         hold_ok    = 1'b1;

    // One add on all three instances; 8-bit expectation supplied by caller.
    task automatic do_add(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                          input logic [9:0] e8, input string tag);
        logic [9:0] ex[3];
        int         lat[3];
        int         bcnt[3];
        bit         seen[3];
        logic [7:0] cs[3];
        logic       cc[3];
        logic       cv[3];
        bit         hold_bad;
        bit         both;
        bit         use_hold;
        ex[0] = e8;
        ex[1] = e8;
        ex[2] = model(3, xa, xb, xc);
        use_hold = hold_ok;
        hold_bad = 1'b0;
        both     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0; bcnt[i] = 0; seen[i] = 1'b0; cs[i] = '0; cc[i] = 1'b0; cv[i] = 1'b0;
        end
        @(negedge clk);
        a = xa; b = xb; ci = xc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        for (int cyc = 0; cyc <= 20; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < 3; i++) begin
                if (!seen[i]) begin
                    if (bz[i]) bcnt[i]++;
                    if (dn[i] && bz[i]) both = 1'b1;
                    if (dn[i]) begin
                        seen[i] = 1'b1; lat[i] = cyc; cs[i] = so[i]; cc[i] = coo[i]; cv[i] = ovo[i];
                    end else if (use_hold && (so[i] !== prev_s[i] || coo[i] !== prev_co[i] || ovo[i] !== prev_ov[i])) begin
                        hold_bad = 1'b1;
                    end
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
        end
        for (int i = 0; i < 3; i++) begin
            if (!seen[i]) begin
                checks++;
                failures++;
                $display("FAIL %s_i%0d_timeout actual=no_done required=done_after_%0d", tag, i, lat_exp[i]);
            end else begin
                chk($sformatf("%s_i%0d_latency", tag, i), lat[i], lat_exp[i]);
                chk($sformatf("%s_i%0d_s", tag, i), cs[i], ex[i][7:0]);
                chk($sformatf("%s_i%0d_co", tag, i), cc[i], ex[i][8]);
                chk($sformatf("%s_i%0d_ov", tag, i), cv[i], ex[i][9]);
                chk($sformatf("%s_i%0d_busy_cycles", tag, i), bcnt[i], lat_exp[i]);
            end
            prev_s[i] = ex[i][7:0]; prev_co[i] = ex[i][8]; prev_ov[i] = ex[i][9];
        end
        if (use_hold) chk({tag, "_hold"}, hold_bad, 0);
        chk({tag, "_done_busy_exclusive"}, both, 0);
        hold_ok = 1'b1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] q[$];
        logic [9:0] e;
        logic [7:0] ra, rb;
        logic       rc;
        int         last_t, pulses;
        bit         saw;

        tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h9C, 8'hA7, 1'b1, 8'h44, 1'b1, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_i%0d_busy", i), bz[i], 0);
            chk($sformatf("reset_i%0d_done", i), dn[i], 0);
            chk($sformatf("reset_i%0d_s", i), so[i], 0);
            chk($sformatf("reset_i%0d_co", i), coo[i], 0);
            chk($sformatf("reset_i%0d_ov", i), ovo[i], 0);
        end
        rst_n = 1'b1;

        // Directed table
        for (int t = 0; t < 6; t++) begin
            do_add(tbl[t].a, tbl[t].b, tbl[t].ci, {tbl[t].ov, tbl[t].co, tbl[t].s}, $sformatf("tbl%0d", t));
        end

        // Exhaustive 3-bit sweep; upper bits random for the 8-bit instances
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                for (int c = 0; c < 2; c++) begin
                    ra = {5'($urandom), x[2:0]};
                    rb = {5'($urandom), y[2:0]};
                    rc = c[0];
                    do_add(ra, rb, rc, model(8, ra, rb, rc), "sweep");
                end
            end
        end

        // Random adds
        for (int r = 0; r < 30; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            do_add(ra, rb, rc, model(8, ra, rb, rc), "rand");
        end

        // start held high in DONE, random during RUN: a result every N+1 cycles
        hold_ok = 1'b0;
        last_t  = -1;
        pulses  = 0;
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        q.push_back(model(8, a, b, ci));
        start = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                e = q.pop_front();
                chk("b2b_s", s8, e[7:0]);
                chk("b2b_co", co8, e[8]);
                chk("b2b_ov", ov8, e[9]);
                if (last_t >= 0) chk("b2b_interval", cyc - last_t, 9);
                last_t = cyc;
                pulses++;
                a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
                q.push_back(model(8, a, b, ci));
                start = 1'b1;
            end else if (busy8) begin
                start = 1'($urandom);
            end
        end
        chk("b2b_pulses", pulses, 6);
        start = 1'b0;
        repeat (15) @(posedge clk);

        // Reset during the 4th RUN cycle
        do_add(8'h35, 8'h4A, 1'b0, model(8, 8'h35, 8'h4A, 1'b0), "pre_reset");
        @(negedge clk);
        a = 8'h12; b = 8'h34; ci = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy8, 0);
        chk("midrst_done", done8, 0);
        chk("midrst_s", s8, 0);
        chk("midrst_co", co8, 0);
        chk("midrst_ov", ov8, 0);
        chk("midrst_s4", s4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) saw = 1'b1;
        end
        chk("midrst_no_done", saw, 0);
        for (int i = 0; i < 3; i++) begin
            prev_s[i] = 8'h00; prev_co[i] = 1'b0; prev_ov[i] = 1'b0;
        end
        hold_ok = 1'b1;
        do_add(8'hC3, 8'h5A, 1'b1, model(8, 8'hC3, 8'h5A, 1'b1), "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
